// File: rtl/neo_bus_pkg.sv
// Shared region types, address decode and FSM encoding for the 68k bus sequencer.
// WDT_CYCLES is only present when WATCHDOG_EN is defined.
package neo_bus_pkg;

    typedef enum logic [2:0] {
        R_ROM   = 3'd0,
        R_RAM   = 3'd1,
        R_P2    = 3'd2,
        R_IO    = 3'd3,
        R_BIOS  = 3'd4,
        R_UNMAP = 3'd5
    } region_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } bus_state_t;

    // Base address nibble, byte address bits [23:20]
    localparam logic [3:0] NIB_ROM  = 4'h0;
    localparam logic [3:0] NIB_RAM  = 4'h1;
    localparam logic [3:0] NIB_P2   = 4'h2;
    localparam logic [3:0] NIB_IO   = 4'h3;
    localparam logic [3:0] NIB_BIOS = 4'hC;

`ifdef WATCHDOG_EN
    localparam logic [23:0] WDT_CYCLES = 24'd8_000_000;
`endif

    function automatic region_t addr_to_region(input logic [3:0] nib);
        case (nib)
            NIB_ROM:  return R_ROM;
            NIB_RAM:  return R_RAM;
            NIB_P2:   return R_P2;
            NIB_IO:   return R_IO;
            NIB_BIOS: return R_BIOS;
            default:  return R_UNMAP;
        endcase
    endfunction

endpackage

// File: rtl/m68k_bus_ctrl_if.sv
// 68000 bus-cycle signals between the CPU side (master) and the bus sequencer (slave).
interface m68k_bus_ctrl_if;

    logic        nAS;
    logic        nUDS;
    logic        nLDS;
    logic        M68K_RW;
    logic [23:1] M68K_ADDR;
    logic        MEM_READY;
    logic        nDTACK;
    logic [5:0]  REGION_SEL;
    logic        BUS_TIMEOUT;
    logic        WDT_RESET;

    modport master (
        output nAS, nUDS, nLDS, M68K_RW, M68K_ADDR, MEM_READY,
        input  nDTACK, REGION_SEL, BUS_TIMEOUT, WDT_RESET
    );

    modport slave (
        input  nAS, nUDS, nLDS, M68K_RW, M68K_ADDR, MEM_READY,
        output nDTACK, REGION_SEL, BUS_TIMEOUT, WDT_RESET
    );

endinterface

// File: rtl/neo_watchdog.sv
// Free-running watchdog: pulses wdt_reset_o after WDT_CYCLES clocks without a kick.
// Built only when WATCHDOG_EN is defined.
`ifdef WATCHDOG_EN
module neo_watchdog
    import neo_bus_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic kick_i,
    output logic wdt_reset_o
);

    logic [23:0] wcd_q;
    logic        pulse_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcd_q   <= '0;
            pulse_q <= 1'b0;
        end else if (wcd_q == WDT_CYCLES - 24'd1) begin
            wcd_q   <= '0;
            pulse_q <= 1'b1;
        end else begin
            wcd_q   <= kick_i ? '0 : wcd_q + 24'd1;
            pulse_q <= 1'b0;
        end
    end

    assign wdt_reset_o = pulse_q;

endmodule
`endif

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle sequencer: region decode, per-region wait states, nDTACK and hung-cycle timeout.
// Optional watchdog enabled by defining WATCHDOG_EN.
module m68k_bus_ctrl
    import neo_bus_pkg::*;
#(
    parameter int unsigned WS_ROM   = 1,
    parameter int unsigned WS_RAM   = 0,
    parameter int unsigned WS_P2    = 2,
    parameter int unsigned WS_IO    = 2,
    parameter int unsigned WS_BIOS  = 1,
    parameter int unsigned WS_UNMAP = 0,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic           CLK_68KCLK,
    input  logic           RESET,
    m68k_bus_ctrl_if.slave bus
);

    bus_state_t       state_q, state_d;
    region_t          region_q, region_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] tcnt_inc;
    logic             armed_q;
    logic             dtack_n_q, dtack_n_d;
    logic [5:0]       sel_q, sel_d;
    logic             timeout_q, timeout_d;
    logic             start;
    region_t          dec;

    function automatic logic [CNT_W-1:0] ws_of(input region_t r);
        case (r)
            R_ROM:   return CNT_W'(WS_ROM);
            R_RAM:   return CNT_W'(WS_RAM);
            R_P2:    return CNT_W'(WS_P2);
            R_IO:    return CNT_W'(WS_IO);
            R_BIOS:  return CNT_W'(WS_BIOS);
            default: return CNT_W'(WS_UNMAP);
        endcase
    endfunction

    assign dec   = addr_to_region(bus.M68K_ADDR[23:20]);
    // A write with both data strobes high has not really started yet
    assign start = armed_q && !bus.nAS && (bus.M68K_RW || !bus.nUDS || !bus.nLDS);
    assign tcnt_inc = (tcnt_q == CNT_W'(TIMEOUT)) ? tcnt_q : tcnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        region_d  = region_q;
        wcnt_d    = wcnt_q;
        tcnt_d    = tcnt_q;
        dtack_n_d = dtack_n_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    region_d = dec;
                    wcnt_d   = ws_of(dec);
                    tcnt_d   = '0;
                    sel_d    = 6'd1 << dec;
                    state_d  = StWait;
                end
            end
            StWait: begin
                wcnt_d = (wcnt_q == '0) ? '0 : wcnt_q - CNT_W'(1);
                tcnt_d = tcnt_inc;
                if (bus.nAS) begin
                    sel_d   = '0;
                    state_d = StIdle;
                end else if (wcnt_q == '0 && (region_q != R_P2 || bus.MEM_READY)) begin
                    dtack_n_d = 1'b0;
                    state_d   = StAck;
                end else if (tcnt_inc == CNT_W'(TIMEOUT)) begin
                    dtack_n_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StAck;
                end
            end
            StAck: begin
                if (bus.nAS) begin
                    dtack_n_d = 1'b1;
                    sel_d     = '0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_68KCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            region_q  <= R_UNMAP;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            armed_q   <= 1'b0;
            dtack_n_q <= 1'b1;
            sel_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            region_q  <= region_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
            armed_q   <= armed_q | bus.nAS;
            dtack_n_q <= dtack_n_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.nDTACK      = dtack_n_q;
    assign bus.REGION_SEL  = sel_q;
    assign bus.BUS_TIMEOUT = timeout_q;

`ifdef WATCHDOG_EN
    logic wdt_kick;
    logic wdt_pulse;

    // Kick on a completed write to byte 0x300001
    assign wdt_kick = (state_q == StWait) && (state_d == StAck) && !bus.M68K_RW &&
                      (region_q == R_IO) && (bus.M68K_ADDR[15:1] == 15'h0000);

    neo_watchdog u_watchdog (
        .clk_i       (CLK_68KCLK),
        .rst_i       (RESET),
        .kick_i      (wdt_kick),
        .wdt_reset_o (wdt_pulse)
    );

    assign bus.WDT_RESET = wdt_pulse;
`else
    assign bus.WDT_RESET = 1'b0;
`endif

endmodule
